// File: rtl/p_encoder_seq.sv
// Sequential priority encoder: captures a request vector and emits the index of
// each set bit, one per valid/ready transfer, in LSB-first or MSB-first order.
module p_encoder_seq #(
    parameter int WIDTH        = 32,
    parameter int IDX_W        = 5,
    parameter int PRIORITY_LSB = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] req_in,
    input  logic             ready,
    output logic             valid,
    output logic [IDX_W-1:0] code,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   count
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Index of the highest-priority set bit; 0 for an empty vector.
    function automatic logic [IDX_W-1:0] pri_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (PRIORITY_LSB != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        code_d    = code_q;
        count_d   = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    pending_d = req_in;
                    count_d   = '0;
                    if (req_in != '0) begin
                        state_d = S_EMIT;
                        code_d  = pri_idx(req_in);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_EMIT: begin
                if (ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << code_q);
                    count_d   = count_q + CNT_W'(1);
                    if (pending_d == '0) begin
                        state_d = S_DONE;
                    end else begin
                        code_d = pri_idx(pending_d);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            code_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            count_q   <= count_d;
        end
    end

    assign valid = (state_q == S_EMIT);
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign code  = code_q;
    assign count = count_q;

endmodule

// File: tb/tb_p_encoder_seq.sv
// Randomized and directed bench for p_encoder_seq; runs LSB-first and MSB-first
// instances side by side against a queue-based reference model.
module tb_p_encoder_seq;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst, load, ready;
    logic [WIDTH-1:0] req_in;

    logic             valid_l, busy_l, done_l;
    logic [IDX_W-1:0] code_l;
    logic [IDX_W:0]   count_l;
    logic             valid_m, busy_m, done_m;
    logic [IDX_W-1:0] code_m;
    logic [IDX_W:0]   count_m;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one ordered queue of indices still to emit per instance.
    int m_phase [2];   // 0 idle, 1 emitting, 2 done
    int m_cnt   [2];
    int m_code  [2];
    int mq      [2][$];

    always #5 clk = ~clk;

    p_encoder_seq #(.WIDTH(WIDTH), .IDX_W(IDX_W), .PRIORITY_LSB(1)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .req_in(req_in), .ready(ready),
        .valid(valid_l), .code(code_l), .busy(busy_l), .done(done_l), .count(count_l)
    );

    p_encoder_seq #(.WIDTH(WIDTH), .IDX_W(IDX_W), .PRIORITY_LSB(0)) dut_msb (
        .clk(clk), .rst(rst), .load(load), .req_in(req_in), .ready(ready),
        .valid(valid_m), .code(code_m), .busy(busy_m), .done(done_m), .count(count_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_cnt[d]   = 0;
            m_code[d]  = 0;
            mq[d].delete();
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            case (m_phase[d])
                0: if (load) begin
                    m_cnt[d] = 0;
                    mq[d].delete();
                    for (int k = 0; k < WIDTH; k++) begin
                        int i;
                        i = (d == 0) ? k : WIDTH - 1 - k;
                        if (req_in[i]) mq[d].push_back(i);
                    end
                    if (mq[d].size() > 0) begin
                        m_phase[d] = 1;
                        m_code[d]  = mq[d][0];
                    end else begin
                        m_phase[d] = 2;
                    end
                end
                1: if (ready) begin
                    void'(mq[d].pop_front());
                    m_cnt[d]++;
                    if (mq[d].size() == 0) m_phase[d] = 2;
                    else m_code[d] = mq[d][0];
                end
                default: m_phase[d] = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("lsb_valid", 32'(valid_l), 32'(m_phase[0] == 1));
        check("lsb_code",  32'(code_l),  32'(m_code[0]));
        check("lsb_busy",  32'(busy_l),  32'(m_phase[0] != 0));
        check("lsb_done",  32'(done_l),  32'(m_phase[0] == 2));
        check("lsb_count", 32'(count_l), 32'(m_cnt[0]));
        check("msb_valid", 32'(valid_m), 32'(m_phase[1] == 1));
        check("msb_code",  32'(code_m),  32'(m_code[1]));
        check("msb_busy",  32'(busy_m),  32'(m_phase[1] != 0));
        check("msb_done",  32'(done_m),  32'(m_phase[1] == 2));
        check("msb_count", 32'(count_m), 32'(m_cnt[1]));
    endtask

    // Drive at the falling edge, clock once, then compare at the next falling edge.
    task automatic cycle(input logic r, input logic ld, input logic [WIDTH-1:0] rq, input logic rdy);
        rst    = r;
        load   = ld;
        req_in = rq;
        ready  = rdy;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [WIDTH-1:0] rq;
        int               done_seen;
        rst = 1'b1; load = 1'b0; req_in = '0; ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held two cycles, then idle with outputs at reset values.
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("rst_code",  32'(code_l),  32'd0);
        check("rst_count", 32'(count_l), 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Three-bit vector with continuous ready: LSB instance 0,4,31; MSB 31,4,0.
        cycle(1'b0, 1'b1, 32'h8000_0011, 1'b1);
        check("lsb_first", 32'(code_l), 32'd0);
        check("msb_first", 32'(code_m), 32'd31);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check("lsb_cnt3", 32'(count_l), 32'd3);

        // Back-pressure holds code 8 stable, then a single transfer.
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        check("bp_code", 32'(code_l), 32'd8);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Empty load goes straight to the done pulse.
        cycle(1'b0, 1'b1, '0, 1'b1);
        check("empty_done", 32'(done_l), 32'd1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Load while busy is ignored.
        cycle(1'b0, 1'b1, 32'h8000_0011, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_000F, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-scan discards pending bits.
        cycle(1'b0, 1'b1, 32'h0000_00FF, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("mid_rst_valid", 32'(valid_l), 32'd0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // All-ones vector: 32 transfers, one done pulse, count reaches 32.
        done_seen = 0;
        cycle(1'b0, 1'b1, '1, 1'b1);
        for (int i = 0; i < 34; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (done_l) done_seen++;
        end
        check("ones_count", 32'(count_l), 32'd32);
        check("ones_done_pulses", 32'(done_seen), 32'd1);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0:       rq = '0;
                1:       rq = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                2:       rq = $urandom & $urandom & $urandom;
                3:       rq = $urandom;
                default: rq = '1;
            endcase
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), rq,
                  ($urandom_range(0, 9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
